// File: rtl/channel_iir_fx.sv
// rtl/channel_iir_fx.sv - complex pole/residue IIR channel filter, fixed point
//
// Each accepted sample x is run through NUM_POLES complex one-pole sections,
// one section per clock. The output y is dc_gain*x plus the sum of the real
// accumulators as they stood before this sample's update.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    sample handshake, in_data = x (signed DW)
//   out_valid/out_ready  result handshake, out_data = y (signed DW, saturated)
//   cfg_we/cfg_addr/     coefficient write port, accepted only while cfg_ready
//   cfg_data/cfg_ready   (addr 4p+{0,1,2,3} = gain_r/gain_i/exp_r/exp_i, 4*NUM_POLES = dc_gain)
//   bypass               pass-through mode, sampled at the input handshake
//   clr_state            zero accumulators and abort any sample in flight
module channel_iir_fx #(
  parameter int NUM_POLES = 6,
  parameter int DW        = 16,
  parameter int CW        = 18,
  parameter int AW        = 24,
  localparam int CAW      = $clog2(4 * NUM_POLES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_data,
  input  logic                 cfg_we,
  input  logic [CAW-1:0]       cfg_addr,
  input  logic signed [CW-1:0] cfg_data,
  output logic                 cfg_ready,
  input  logic                 bypass,
  input  logic                 clr_state
);

  localparam int Q  = CW - 2;                                  // coefficient fraction bits
  localparam int PW = CW + AW;                                 // coef * accumulator product
  localparam int XW = CW + DW;                                 // coef * sample product
  localparam int SW = PW + 2;                                  // pole update sum, never overflows
  localparam int YW = SW + 5;                                  // output sum over up to 16 poles
  localparam int IW = (NUM_POLES > 1) ? $clog2(NUM_POLES) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;

  logic signed [CW-1:0] gain_r [NUM_POLES];
  logic signed [CW-1:0] gain_i [NUM_POLES];
  logic signed [CW-1:0] exp_r  [NUM_POLES];
  logic signed [CW-1:0] exp_i  [NUM_POLES];
  logic signed [CW-1:0] dc_gain;
  logic signed [AW-1:0] ac_r   [NUM_POLES];
  logic signed [AW-1:0] ac_i   [NUM_POLES];

  logic signed [DW-1:0] x_q;
  logic signed [YW-1:0] y_acc;
  logic [IW-1:0]        idx;

  logic                 accept, last;
  logic signed [CW-1:0] sel_gr, sel_gi, sel_er, sel_ei;
  logic signed [AW-1:0] sel_acr, sel_aci;
  logic signed [PW-1:0] p_rr, p_ii, p_ir, p_ri;
  logic signed [XW-1:0] p_gr, p_gi, p_dc;
  logic signed [SW-1:0] t_r, t_i;
  logic signed [YW-1:0] y_next;

  function automatic logic signed [AW-1:0] sat_acc(input logic signed [SW-1:0] v);
    if (v[SW-1:AW-1] == {(SW-AW+1){v[SW-1]}}) return v[AW-1:0];
    else if (v[SW-1])                        return {1'b1, {(AW-1){1'b0}}};
    else                                     return {1'b0, {(AW-1){1'b1}}};
  endfunction

  function automatic logic signed [DW-1:0] sat_out(input logic signed [YW-1:0] v);
    if (v[YW-1:DW-1] == {(YW-DW+1){v[YW-1]}}) return v[DW-1:0];
    else if (v[YW-1])                        return {1'b1, {(DW-1){1'b0}}};
    else                                     return {1'b0, {(DW-1){1'b1}}};
  endfunction

  // rst gates in_ready directly so nothing is offered while reset is held
  assign in_ready  = (state_q == IDLE) && !clr_state && !rst && (!out_valid || out_ready);
  assign cfg_ready = (state_q == IDLE);
  assign accept    = in_valid && in_ready;
  assign last      = (idx == IW'(NUM_POLES - 1));

  // Pole currently being processed
  always_comb begin
    sel_gr  = '0;
    sel_gi  = '0;
    sel_er  = '0;
    sel_ei  = '0;
    sel_acr = '0;
    sel_aci = '0;
    for (int p = 0; p < NUM_POLES; p++) begin
      if (idx == IW'(p)) begin
        sel_gr  = gain_r[p];
        sel_gi  = gain_i[p];
        sel_er  = exp_r[p];
        sel_ei  = exp_i[p];
        sel_acr = ac_r[p];
        sel_aci = ac_i[p];
      end
    end
  end

  assign p_rr = PW'(sel_er) * PW'(sel_acr);
  assign p_ii = PW'(sel_ei) * PW'(sel_aci);
  assign p_ir = PW'(sel_ei) * PW'(sel_acr);
  assign p_ri = PW'(sel_er) * PW'(sel_aci);
  assign p_gr = XW'(sel_gr) * XW'(x_q);
  assign p_gi = XW'(sel_gi) * XW'(x_q);
  assign p_dc = XW'(dc_gain) * XW'(in_data);

  // Every product is floored to the sample LSB before it is summed
  assign t_r    = SW'(p_rr >>> Q) - SW'(p_ii >>> Q) + SW'(p_gr >>> Q);
  assign t_i    = SW'(p_ir >>> Q) + SW'(p_ri >>> Q) + SW'(p_gi >>> Q);
  assign y_next = y_acc + YW'(sel_acr);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && !bypass) state_d = CALC;
      CALC:    if (last)              state_d = DONE;
      DONE:    if (out_ready)         state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
    if (clr_state) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < NUM_POLES; p++) begin
        gain_r[p] <= '0;
        gain_i[p] <= '0;
        exp_r[p]  <= '0;
        exp_i[p]  <= '0;
        ac_r[p]   <= '0;
        ac_i[p]   <= '0;
      end
      dc_gain   <= '0;
      x_q       <= '0;
      y_acc     <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (cfg_we && cfg_ready) begin
        for (int p = 0; p < NUM_POLES; p++) begin
          if (cfg_addr == CAW'(4 * p))     gain_r[p] <= cfg_data;
          if (cfg_addr == CAW'(4 * p + 1)) gain_i[p] <= cfg_data;
          if (cfg_addr == CAW'(4 * p + 2)) exp_r[p]  <= cfg_data;
          if (cfg_addr == CAW'(4 * p + 3)) exp_i[p]  <= cfg_data;
        end
        if (cfg_addr == CAW'(4 * NUM_POLES)) dc_gain <= cfg_data;
      end

      if (clr_state) begin
        for (int p = 0; p < NUM_POLES; p++) begin
          ac_r[p] <= '0;
          ac_i[p] <= '0;
        end
        idx       <= '0;
        out_valid <= 1'b0;
      end else begin
        if (out_valid && out_ready) out_valid <= 1'b0;

        if (accept) begin
          if (bypass) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
          end else begin
            x_q   <= in_data;
            y_acc <= YW'(p_dc >>> Q);
            idx   <= '0;
          end
        end

        // y collects each pole's old ac_r just before that pole is overwritten
        if (state_q == CALC) begin
          for (int p = 0; p < NUM_POLES; p++) begin
            if (idx == IW'(p)) begin
              ac_r[p] <= sat_acc(t_r);
              ac_i[p] <= sat_acc(t_i);
            end
          end
          y_acc <= y_next;
          idx   <= idx + 1'b1;
          if (last) begin
            out_data  <= sat_out(y_next);
            out_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: doc/channel_iir_fx.md
CHANNEL_IIR_FX -- requirements
Module: channel_iir_fx

Interface
REQ-001 Parameter NUM_POLES, default 6: number of complex pole/residue sections, legal range 1..16.
REQ-002 Parameter DW, default 16: signed sample width, integer LSB.
REQ-003 Parameter CW, default 18: signed coefficient width in Q2.(CW-2); 1.0 = 2^(CW-2).
REQ-004 Parameter AW, default 24: signed accumulator width, same LSB as samples.
REQ-005 Port list, one per line (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  sample x offered.
- in_ready  out  1  block accepts sample.
- in_data  in  DW  sample x.
- out_valid  out  1  result y available.
- out_ready  in  1  downstream accepts y.
- out_data  out  DW  result y, saturated.
- cfg_we  in  1  coefficient write strobe.
- cfg_addr  in  clog2(4*NUM_POLES+1)  coefficient index.
- cfg_data  in  CW  coefficient value.
- cfg_ready  out  1  high when writes are accepted.
- bypass  in  1  mode select, 1 = pass-through.
- clr_state  in  1  synchronous accumulator clear.

Function
REQ-006 Coefficient map: addr 4p+0 = gain_r, 4p+1 = gain_i, 4p+2 = exp_r, 4p+3 = exp_i for pole p; addr 4*NUM_POLES = dc_gain; writes to out-of-range addresses are ignored.
REQ-007 cfg_ready is high only in IDLE; a cfg_we while cfg_ready is low is dropped with no side effects.
REQ-008 The FSM has three states. IDLE -> CALC on an input handshake (in_valid & in_ready). CALC lasts exactly NUM_POLES cycles, one pole per cycle in order p = 0..NUM_POLES-1, then moves to DONE. DONE -> IDLE on out_ready.
REQ-009 in_ready is high only in IDLE with bypass low or, in bypass, when out_valid is low or out_ready is high.
REQ-010 Per pole, with x as the latched sample, the block computes:
- ac_r' = sat(er*ac_r - ei*ac_i + gr*x)
- ac_i' = sat(ei*ac_r + er*ac_i + gi*x)
REQ-011 Each product is arithmetically shifted right by CW-2 (floor) before summation; the sum is saturated to AW bits.
REQ-012 y = sat_DW( (dc_gain*x >>> (CW-2)) + sum of all ac_r values before the update of this sample ); the output carries a one-sample state delay.
REQ-013 out_valid rises NUM_POLES+1 cycles after the input handshake. It and out_data hold stable until out_ready is sampled high.
REQ-014 Bypass: out_data = in_data and out_valid is asserted the cycle after the handshake; accumulators are not updated. bypass is sampled only at the handshake.
REQ-015 clr_state zeroes all accumulators, aborts CALC, deasserts out_valid and returns the FSM to IDLE in the same cycle. It has priority over a simultaneous in_valid, which is not accepted (in_ready is low while clr_state is high).
REQ-016 Saturation never wraps: any overflow clamps to the maximum or minimum representable value of the destination width.

Reset
REQ-017 rst forces the following, with no clock required:
- FSM to IDLE.
- All accumulators and coefficients to 0.
- out_valid = 0, out_data = 0, in_ready = 0 while rst is high.
- cfg_ready = 1 after rst is released.
REQ-018 rst asserted mid-CALC or in DONE discards the pending sample; no output handshake follows.

Verification
REQ-019 Impulse (NUM_POLES = 1; gr = 65536, er = 32768, others 0; x = 1000 then 0,0,0) -> y = 0, 1000, 500, 250.
REQ-020 Complex pole (er = 0, ei = 65536, gr = 65536; x = 100 then 0s) -> ac_r/ac_i rotate 90 degrees per sample; y = 0, 100, 0, -100, 0, 100.
REQ-021 Saturation (gr = 131071, er = 65536; x = 32767 repeated) -> ac_r clamps at 8388607, y clamps at 32767, never wraps negative.
REQ-022 Backpressure (out_ready held low 10 cycles) -> out_data stable, in_ready low, no sample lost or duplicated after release.
REQ-023 clr_state asserted mid-CALC together with in_valid -> out_valid stays 0, the input is not accepted, and the next impulse response matches REQ-019 from zero state.
REQ-024 Config lockout and reset: a cfg_we during CALC is ignored, so readback behaviour is unchanged; an async rst mid-CALC gives out_valid = 0 immediately and all coefficients = 0.
